// File: rtl/mem_stage_ctl.sv
// Memory pipeline stage between EX/MEM and MEM/WB: a request/acknowledge data port with
// byte/half/word access and an upstream stall. Define MEM_ALIGN_CHECK_EN to trap misaligned accesses.
//
// state | meaning
// IDLE  | pipeline-register mode; a memory access here launches a request
// BUSY  | request outstanding; waiting for dmem_ack, bubbles into MEM/WB
module mem_stage_ctl #(
   parameter int ADDR_W = 9,
   parameter int REG_W  = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ex_mem_readmem,
   input  logic              ex_mem_writemem,
   input  logic [1:0]        ex_mem_size,
   input  logic              ex_mem_unsigned,
   input  logic [31:0]       ex_mem_regb,
   input  logic              ex_mem_selwsource,
   input  logic [REG_W-1:0]  ex_mem_regdest,
   input  logic              ex_mem_writereg,
   input  logic [31:0]       ex_mem_wbvalue,
   output logic              mem_stall,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [3:0]        dmem_be,
   output logic [31:0]       dmem_wdata,
   input  logic [31:0]       dmem_rdata,
   input  logic              dmem_ack,
   output logic [REG_W-1:0]  mem_wb_regdest,
   output logic              mem_wb_writereg,
   output logic [31:0]       mem_wb_wbvalue,
   output logic              mem_wb_exc
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   logic [0:0]  state;
   logic        access;
   logic [1:0]  b;
   logic        sz_byte;
   logic        sz_half;
   logic        sz_word;
   logic        misaligned;
   logic [3:0]  be_nxt;
   logic [31:0] wdata_nxt;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] load_data;
   logic        unused_addr_hi;

   assign access  = ex_mem_readmem | ex_mem_writemem;
   assign b       = ex_mem_wbvalue[1:0];
   assign sz_byte = (ex_mem_size == 2'b00);
   assign sz_half = (ex_mem_size == 2'b01);
   assign sz_word = ex_mem_size[1];

   // Address bits above the data-memory window carry no meaning here.
   assign unused_addr_hi = ^ex_mem_wbvalue[31:ADDR_W+2];

`ifdef MEM_ALIGN_CHECK_EN
   assign misaligned = access & ((sz_half & b[0]) | (sz_word & (b != 2'b00)));
`else
   assign misaligned = 1'b0;
`endif

   always_comb begin
      be_nxt    = 4'b1111;
      wdata_nxt = ex_mem_regb;
      if (sz_byte) begin
         be_nxt    = 4'b0001 << b;
         wdata_nxt = {4{ex_mem_regb[7:0]}};
      end else if (sz_half) begin
         be_nxt    = b[1] ? 4'b1100 : 4'b0011;
         wdata_nxt = {2{ex_mem_regb[15:0]}};
      end
   end

   always_comb begin
      case (b)
         2'd0:    byte_lane = dmem_rdata[7:0];
         2'd1:    byte_lane = dmem_rdata[15:8];
         2'd2:    byte_lane = dmem_rdata[23:16];
         default: byte_lane = dmem_rdata[31:24];
      endcase
      half_lane = b[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      load_data = dmem_rdata;
      if (sz_byte) begin
         load_data = {{24{~ex_mem_unsigned & byte_lane[7]}}, byte_lane};
      end else if (sz_half) begin
         load_data = {{16{~ex_mem_unsigned & half_lane[15]}}, half_lane};
      end
   end

   // Stall is forced low under reset so a held access cannot freeze upstream.
   always_comb begin
      mem_stall = 1'b0;
      if (reset) begin
         case (state)
            ST_IDLE: mem_stall = access & ~misaligned;
            ST_BUSY: mem_stall = ~dmem_ack;
            default: mem_stall = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state           <= ST_IDLE;
         dmem_req        <= 1'b0;
         dmem_we         <= 1'b0;
         dmem_addr       <= '0;
         dmem_be         <= 4'b0000;
         dmem_wdata      <= 32'd0;
         mem_wb_regdest  <= '0;
         mem_wb_writereg <= 1'b0;
         mem_wb_wbvalue  <= 32'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (access & ~misaligned) begin
                  state           <= ST_BUSY;
                  dmem_req        <= 1'b1;
                  dmem_we         <= ex_mem_writemem;
                  dmem_addr       <= ex_mem_wbvalue[ADDR_W+1:2];
                  dmem_be         <= be_nxt;
                  dmem_wdata      <= wdata_nxt;
                  mem_wb_writereg <= 1'b0;
               end else if (misaligned) begin
                  mem_wb_writereg <= 1'b0;
               end else begin
                  mem_wb_regdest  <= ex_mem_regdest;
                  mem_wb_writereg <= ex_mem_writereg;
                  mem_wb_wbvalue  <= ex_mem_wbvalue;
               end
            end
            ST_BUSY: begin
               if (dmem_ack) begin
                  state           <= ST_IDLE;
                  dmem_req        <= 1'b0;
                  mem_wb_regdest  <= ex_mem_regdest;
                  mem_wb_writereg <= ex_mem_writereg;
                  mem_wb_wbvalue  <= ex_mem_selwsource ? load_data : ex_mem_wbvalue;
               end else begin
                  mem_wb_writereg <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef MEM_ALIGN_CHECK_EN
   logic exc_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         exc_q <= 1'b0;
      end else begin
         exc_q <= (state == ST_IDLE) & misaligned;
      end
   end

   assign mem_wb_exc = exc_q;
`else
   assign mem_wb_exc = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_ctl.sv
// Self-checking bench for mem_stage_ctl: directed vector table, reset/misalignment sequences
// and randomized instructions compared against an arithmetic reference model.
module tb_mem_stage_ctl;

   logic        clock;
   logic        reset;
   logic        ex_mem_readmem;
   logic        ex_mem_writemem;
   logic [1:0]  ex_mem_size;
   logic        ex_mem_unsigned;
   logic [31:0] ex_mem_regb;
   logic        ex_mem_selwsource;
   logic [4:0]  ex_mem_regdest;
   logic        ex_mem_writereg;
   logic [31:0] ex_mem_wbvalue;
   logic        mem_stall;
   logic        dmem_req;
   logic        dmem_we;
   logic [8:0]  dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   logic [4:0]  mem_wb_regdest;
   logic        mem_wb_writereg;
   logic [31:0] mem_wb_wbvalue;
   logic        mem_wb_exc;

   int errors = 0;
   int checks = 0;

   mem_stage_ctl #(.ADDR_W(9), .REG_W(5)) dut (
      .clock             (clock),
      .reset             (reset),
      .ex_mem_readmem    (ex_mem_readmem),
      .ex_mem_writemem   (ex_mem_writemem),
      .ex_mem_size       (ex_mem_size),
      .ex_mem_unsigned   (ex_mem_unsigned),
      .ex_mem_regb       (ex_mem_regb),
      .ex_mem_selwsource (ex_mem_selwsource),
      .ex_mem_regdest    (ex_mem_regdest),
      .ex_mem_writereg   (ex_mem_writereg),
      .ex_mem_wbvalue    (ex_mem_wbvalue),
      .mem_stall         (mem_stall),
      .dmem_req          (dmem_req),
      .dmem_we           (dmem_we),
      .dmem_addr         (dmem_addr),
      .dmem_be           (dmem_be),
      .dmem_wdata        (dmem_wdata),
      .dmem_rdata        (dmem_rdata),
      .dmem_ack          (dmem_ack),
      .mem_wb_regdest    (mem_wb_regdest),
      .mem_wb_writereg   (mem_wb_writereg),
      .mem_wb_wbvalue    (mem_wb_wbvalue),
      .mem_wb_exc        (mem_wb_exc)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] regb;
      logic        selw;
      logic [4:0]  rdst;
      logic        wreg;
      logic [31:0] wbv;
      int          lat;
      logic [31:0] rdata;
      logic        idle_ack;
   } instr_t;

   typedef struct {
      logic        acc;
      logic        mis;
      logic        we;
      logic [8:0]  addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] val;
   } exp_t;

   typedef struct {
      instr_t      in;
      logic [31:0] val;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [8:0]  addr;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic instr_t mk(input logic rd, input logic wr, input logic [1:0] size,
                                 input logic uns, input logic [31:0] regb, input logic selw,
                                 input logic [4:0] rdst, input logic wreg, input logic [31:0] wbv,
                                 input int lat, input logic [31:0] rdata, input logic idle_ack);
      instr_t i;
      i.rd = rd; i.wr = wr; i.size = size; i.uns = uns; i.regb = regb; i.selw = selw;
      i.rdst = rdst; i.wreg = wreg; i.wbv = wbv; i.lat = lat; i.rdata = rdata;
      i.idle_ack = idle_ack;
      return i;
   endfunction

   // Reference: byte address arithmetic and shifts, straight from the access rules.
   function automatic exp_t model(input instr_t i);
      exp_t        e;
      int          b;
      int          sh;
      logic [31:0] x;
      b      = int'(i.wbv % 4);
      e.acc  = i.rd | i.wr;
      e.we   = i.wr;
`ifdef MEM_ALIGN_CHECK_EN
      e.mis  = e.acc && ((i.size == 2'd1 && (b % 2) == 1) || (i.size >= 2'd2 && b != 0));
`else
      e.mis  = 1'b0;
`endif
      e.addr = 9'((i.wbv / 4) % 512);
      if (i.size == 2'd0) begin
         e.be    = 4'(1 << b);
         e.wdata = {24'd0, i.regb[7:0]} * 32'h0101_0101;
         x       = (i.rdata >> (8 * b)) & 32'hFF;
         if (!i.uns && x >= 32'd128) x = x + 32'hFFFF_FF00;
      end else if (i.size == 2'd1) begin
         sh      = (b >= 2) ? 2 : 0;
         e.be    = 4'(3 << sh);
         e.wdata = (i.regb & 32'hFFFF) * 32'h0001_0001;
         x       = (i.rdata >> (8 * sh)) & 32'hFFFF;
         if (!i.uns && x >= 32'd32768) x = x + 32'hFFFF_0000;
      end else begin
         e.be    = 4'hF;
         e.wdata = i.regb;
         x       = i.rdata;
      end
      e.val = (e.acc && i.selw) ? x : i.wbv;
      return e;
   endfunction

   // Entered and left at a falling edge; acts as the data memory with latency i.lat.
   task automatic run(input instr_t i, input exp_t e);
      int         stall_cnt;
      logic [8:0] addr_seen;
      ex_mem_readmem    = i.rd;
      ex_mem_writemem   = i.wr;
      ex_mem_size       = i.size;
      ex_mem_unsigned   = i.uns;
      ex_mem_regb       = i.regb;
      ex_mem_selwsource = i.selw;
      ex_mem_regdest    = i.rdst;
      ex_mem_writereg   = i.wreg;
      ex_mem_wbvalue    = i.wbv;
      dmem_ack          = e.acc ? 1'b0 : i.idle_ack;
      dmem_rdata        = $urandom;
      #1;
      chk("stall_idle", 32'(mem_stall), 32'(e.acc && !e.mis));
      @(posedge clock);
      @(negedge clock);
      if (!e.acc || e.mis) begin
         chk("req_none", 32'(dmem_req), 32'd0);
         chk("wb_writereg", 32'(mem_wb_writereg), 32'(e.mis ? 1'b0 : i.wreg));
         chk("wb_exc", 32'(mem_wb_exc), 32'(e.mis));
         if (!e.mis) begin
            chk("wb_regdest", 32'(mem_wb_regdest), 32'(i.rdst));
            chk("wb_value", mem_wb_wbvalue, e.val);
         end
         return;
      end
      chk("req_set", 32'(dmem_req), 32'd1);
      chk("req_we", 32'(dmem_we), 32'(e.we));
      chk("req_addr", 32'(dmem_addr), 32'(e.addr));
      chk("req_be", 32'(dmem_be), 32'(e.be));
      chk("req_wdata", dmem_wdata, e.wdata);
      chk("bubble_first", 32'(mem_wb_writereg), 32'd0);
      addr_seen = dmem_addr;
      stall_cnt = 1;
      for (int k = 1; k <= i.lat; k++) begin
         dmem_ack   = (k == i.lat);
         dmem_rdata = (k == i.lat) ? i.rdata : $urandom;
         #1;
         if (mem_stall) stall_cnt++;
         @(posedge clock);
         @(negedge clock);
         if (k < i.lat) begin
            chk("busy_req", 32'(dmem_req), 32'd1);
            chk("busy_bubble", 32'(mem_wb_writereg), 32'd0);
            chk("busy_addr", 32'(dmem_addr), 32'(addr_seen));
         end
      end
      chk("stall_cycles", 32'(stall_cnt), 32'(i.lat));
      chk("ack_req_drop", 32'(dmem_req), 32'd0);
      chk("ack_regdest", 32'(mem_wb_regdest), 32'(i.rdst));
      chk("ack_writereg", 32'(mem_wb_writereg), 32'(i.wreg));
      chk("ack_value", mem_wb_wbvalue, e.val);
      chk("ack_exc", 32'(mem_wb_exc), 32'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req"}, 32'(dmem_req), 32'd0);
      chk({tag, "_we"}, 32'(dmem_we), 32'd0);
      chk({tag, "_addr"}, 32'(dmem_addr), 32'd0);
      chk({tag, "_be"}, 32'(dmem_be), 32'd0);
      chk({tag, "_wdata"}, dmem_wdata, 32'd0);
      chk({tag, "_regdest"}, 32'(mem_wb_regdest), 32'd0);
      chk({tag, "_writereg"}, 32'(mem_wb_writereg), 32'd0);
      chk({tag, "_wbvalue"}, mem_wb_wbvalue, 32'd0);
      chk({tag, "_exc"}, 32'(mem_wb_exc), 32'd0);
      chk({tag, "_stall"}, 32'(mem_stall), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t   e;
      instr_t ins;

      tbl[0].in  = mk(0, 0, 2'd0, 0, 32'h0, 0, 5'd7, 1, 32'h0000_1234, 1, 32'h0, 0);
      tbl[0].val = 32'h0000_1234; tbl[0].be = 4'h0; tbl[0].wdata = 32'h0; tbl[0].addr = 9'd0;
      tbl[1].in  = mk(1, 0, 2'd0, 0, 32'h55, 1, 5'd3, 1, 32'h003, 4, 32'h80FF_0011, 0);
      tbl[1].val = 32'hFFFF_FF80; tbl[1].be = 4'b1000; tbl[1].wdata = 32'h5555_5555; tbl[1].addr = 9'd0;
      tbl[2].in  = mk(0, 1, 2'd1, 0, 32'hABCD_1234, 0, 5'd9, 1, 32'h006, 1, 32'h0, 0);
      tbl[2].val = 32'h0000_0006; tbl[2].be = 4'b1100; tbl[2].wdata = 32'h1234_1234; tbl[2].addr = 9'd1;
      tbl[3].in  = mk(1, 1, 2'd2, 0, 32'hDEAD_BEEF, 0, 5'd2, 0, 32'h010, 2, 32'h0, 0);
      tbl[3].val = 32'h0000_0010; tbl[3].be = 4'b1111; tbl[3].wdata = 32'hDEAD_BEEF; tbl[3].addr = 9'd4;
      tbl[4].in  = mk(1, 0, 2'd2, 1, 32'h0, 1, 5'd4, 1, 32'h008, 1, 32'h8000_0001, 0);
      tbl[4].val = 32'h8000_0001; tbl[4].be = 4'b1111; tbl[4].wdata = 32'h0; tbl[4].addr = 9'd2;
      tbl[5].in  = mk(1, 0, 2'd1, 0, 32'h0, 1, 5'd5, 1, 32'h002, 2, 32'h8001_7FFF, 0);
      tbl[5].val = 32'hFFFF_8001; tbl[5].be = 4'b1100; tbl[5].wdata = 32'h0; tbl[5].addr = 9'd0;
      tbl[6].in  = mk(1, 0, 2'd1, 1, 32'h0, 1, 5'd6, 1, 32'h000, 1, 32'h8001_F00F, 0);
      tbl[6].val = 32'h0000_F00F; tbl[6].be = 4'b0011; tbl[6].wdata = 32'h0; tbl[6].addr = 9'd0;
      tbl[7].in  = mk(1, 0, 2'd0, 1, 32'h0, 1, 5'd8, 1, 32'h001, 3, 32'h1234_A578, 0);
      tbl[7].val = 32'h0000_00A5; tbl[7].be = 4'b0010; tbl[7].wdata = 32'h0; tbl[7].addr = 9'd0;
      tbl[8].in  = mk(1, 0, 2'd0, 0, 32'h0, 1, 5'd10, 1, 32'h7FE, 1, 32'h007F_0000, 0);
      tbl[8].val = 32'h0000_007F; tbl[8].be = 4'b0100; tbl[8].wdata = 32'h0; tbl[8].addr = 9'h1FF;
      tbl[9].in  = mk(0, 1, 2'd0, 0, 32'hC3, 0, 5'd11, 1, 32'h8000_0805, 2, 32'h0, 0);
      tbl[9].val = 32'h8000_0805; tbl[9].be = 4'b0010; tbl[9].wdata = 32'hC3C3_C3C3; tbl[9].addr = 9'd1;
      tbl[10].in  = mk(1, 0, 2'd3, 0, 32'h0, 1, 5'd12, 1, 32'h00C, 1, 32'hCAFE_F00D, 0);
      tbl[10].val = 32'hCAFE_F00D; tbl[10].be = 4'b1111; tbl[10].wdata = 32'h0; tbl[10].addr = 9'd3;
      tbl[11].in  = mk(0, 0, 2'd0, 0, 32'h0, 0, 5'd31, 0, 32'hFFFF_FFFF, 1, 32'h0, 1);
      tbl[11].val = 32'hFFFF_FFFF; tbl[11].be = 4'h0; tbl[11].wdata = 32'h0; tbl[11].addr = 9'd0;

      reset = 1'b0;
      ex_mem_readmem = 0; ex_mem_writemem = 0; ex_mem_size = 0; ex_mem_unsigned = 0;
      ex_mem_regb = 0; ex_mem_selwsource = 0; ex_mem_regdest = 0; ex_mem_writereg = 0;
      ex_mem_wbvalue = 0; dmem_rdata = 0; dmem_ack = 0;
      @(negedge clock);
      chk_all_zero("rst");
      reset = 1'b1;

      foreach (tbl[k]) begin
         e       = model(tbl[k].in);
         e.val   = tbl[k].val;
         e.be    = tbl[k].be;
         e.wdata = tbl[k].wdata;
         e.addr  = tbl[k].addr;
         run(tbl[k].in, e);
      end

      // Word load at byte offset 2: trapped when the check is built in, lane 0 otherwise.
      ins = mk(1, 0, 2'd2, 0, 32'h0, 1, 5'd13, 1, 32'h002, 1, 32'h1122_3344, 0);
      e.acc = 1'b1; e.we = 1'b0; e.addr = 9'd0; e.be = 4'hF; e.wdata = 32'h0;
      e.val = 32'h1122_3344;
`ifdef MEM_ALIGN_CHECK_EN
      e.mis = 1'b1;
`else
      e.mis = 1'b0;
`endif
      run(ins, e);
      ins = mk(0, 0, 2'd0, 0, 32'h0, 0, 5'd14, 1, 32'h0000_0042, 1, 32'h0, 0);
      run(ins, model(ins));

      // Reset in the middle of an outstanding load; a late ack must not write back.
      ex_mem_readmem = 1; ex_mem_writemem = 0; ex_mem_size = 2'd2; ex_mem_selwsource = 1;
      ex_mem_regdest = 5'd20; ex_mem_writereg = 1; ex_mem_wbvalue = 32'h20; dmem_ack = 0;
      @(posedge clock); @(negedge clock);
      @(posedge clock); @(negedge clock);
      chk("mid_busy_req", 32'(dmem_req), 32'd1);
      reset = 1'b0;
      #1;
      chk_all_zero("mid_rst");
      ex_mem_readmem = 0; ex_mem_writereg = 0; dmem_ack = 1; dmem_rdata = 32'h9999_9999;
      @(posedge clock); @(negedge clock);
      reset = 1'b1;
      #1;
      chk("late_ack_stall", 32'(mem_stall), 32'd0);
      @(posedge clock); @(negedge clock);
      chk("late_ack_req", 32'(dmem_req), 32'd0);
      chk("late_ack_writereg", 32'(mem_wb_writereg), 32'd0);
      ins = mk(0, 0, 2'd0, 0, 32'h0, 0, 5'd5, 1, 32'h0000_0ABC, 1, 32'h0, 0);
      run(ins, model(ins));

      for (int n = 0; n < 200; n++) begin
         ins.rd       = 1'($urandom_range(0, 1));
         ins.wr       = ($urandom_range(0, 3) == 0);
         ins.size     = 2'($urandom_range(0, 3));
         ins.uns      = 1'($urandom_range(0, 1));
         ins.regb     = $urandom;
         ins.selw     = 1'($urandom_range(0, 1));
         ins.rdst     = 5'($urandom_range(0, 31));
         ins.wreg     = 1'($urandom_range(0, 1));
         ins.wbv      = $urandom;
         ins.lat      = $urandom_range(1, 4);
         ins.rdata    = $urandom;
         ins.idle_ack = 1'($urandom_range(0, 1));
         run(ins, model(ins));
      end

      dmem_ack = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
